jk_excitation_driver: RTL

- Control-side counterpart to the team's JK flip-flop: drives the J/K inputs of an external W-bit bank of JK flip-flops so that the bank reaches a requested value.
- Accepts one request at a time over a valid/ready handshake.
- Derives each bit's J/K from the JK excitation table, drives it for exactly one cycle, then reads the bank's Q back and reports done or mismatch.
- Sits between sequencing logic and a register built from JK flip-flops.

---
 rtl/jk_pkg.sv | 16 +
 rtl/jk_excite.sv | 24 ++
 rtl/jk_excitation_driver.sv | 98 +++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver.
// Request mode encodings and the driver FSM state enum.
package jk_pkg;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_INC   = 2'b01;
  localparam logic [1:0] MODE_DEC   = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation table, W bits wide.
// Ports: cur/nxt (present/wanted Q), use_toggle, j/k outputs.
module jk_excite
  import jk_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] nxt,
  input  logic         use_toggle,
  output logic [W-1:0] j,
  output logic [W-1:0] k
);

  logic [W-1:0] chg;

  assign chg = cur ^ nxt;

  // Toggle mode drives J=K=1 on every changing bit;
  // otherwise set rising bits, reset falling bits.
  assign j = use_toggle ? chg : (chg & nxt);
  assign k = use_toggle ? chg : (chg & cur);

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives J/K of an external JK bank to reach a requested value.
// Ports: clk, reset, req_* handshake, q_in, j/k, done/err, busy.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int W          = 4,
  parameter int USE_TOGGLE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_mode,
  input  logic [W-1:0] req_data,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         done,
  output logic         err,
  output logic         busy
);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] target;
  logic [W-1:0] tgt_nxt;
  logic [W-1:0] ex_j;
  logic [W-1:0] ex_k;
  logic         accept;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    tgt_nxt = '0;
    unique case (1'b1)
      (req_mode == MODE_LOAD):  tgt_nxt = req_data;
      (req_mode == MODE_INC):   tgt_nxt = q_in + W'(1);
      (req_mode == MODE_DEC):   tgt_nxt = q_in - W'(1);
      (req_mode == MODE_CLEAR): tgt_nxt = '0;
      default:                  tgt_nxt = '0;
    endcase
  end

  jk_excite #(
    .W(W)
  ) u_excite (
    .cur       (q_in),
    .nxt       (tgt_nxt),
    .use_toggle(USE_TOGGLE != 0),
    .j         (ex_j),
    .k         (ex_k)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = DRIVE;
      DRIVE:   state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // j/k are loaded only on accept, so they are
  // nonzero for the single DRIVE cycle that follows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= '0;
      j      <= '0;
      k      <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= (state == CHECK) && (q_in == target);
      err  <= (state == CHECK) && (q_in != target);
      if (accept) begin
        target <= tgt_nxt;
        j      <= ex_j;
        k      <= ex_k;
      end else begin
        j <= '0;
        k <= '0;
      end
    end
  end

  assign busy      = (state == DRIVE) || (state == CHECK);
  assign req_ready = (state == IDLE) && !reset;

endmodule
